cdr_acq_ctrl: RTL and testbench
===============================

Name: cdr_acq_ctrl

Overview:
Acquisition and gear-shift sequencer for the bang-bang CDR core. It watches the core's phase-detector decisions on each sample strobe and steps the loop through frequency acquisition, phase acquisition and tracking. In each step it drives the proportional/integral gain shifts and the integrator controls into the core. It also runs a windowed lock detector and restarts acquisition on loss of lock.

Parameters:
WIN_LOG2, 8, lock window = 2^WIN_LOG2 qualified PD samples
ACQ_DWELL, 4096, qualified PD samples spent in FACQ (16-bit counter)
LOCK_THR, 32, window |sum| <= this counts as a good window
UNLOCK_THR, 96, window |sum| > this in TRACK declares loss of lock
LOCK_WINS, 4, consecutive good windows needed in PACQ to declare lock
MAX_WINS, 64, PACQ window budget before retrying FACQ
KP_F/KP_P/KP_T, 2/4/6, proportional right-shift in FACQ/PACQ/TRACK (4-bit)
KI_F/KI_P/KI_T, 6/9/12, integral right-shift in FACQ/PACQ/TRACK (4-bit)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
en  in  1  sequencer enable; 0 forces IDLE
sample_en  in  1  CDR sample strobe, one cycle wide
pd_sign  in  1  bang-bang decision at strobe (1 = late, +1; 0 = early, -1)
kp_shift  out  4  proportional gain shift to core
ki_shift  out  4  integral gain shift to core
int_freeze  out  1  hold the core's frequency integrator
int_clr  out  1  one-cycle pulse clearing the core's integrator
lock  out  1  loop locked
state  out  2  IDLE=0, FACQ=1, PACQ=2, TRACK=3
retry_cnt  out  4  saturating count of PACQ timeouts since leaving IDLE
lol_cnt  out  8  loss-of-lock event count (optional feature)

Behaviour:
- Reset values: state=IDLE, kp_shift=KP_F, ki_shift=KI_F, int_freeze=1, int_clr=0, lock=0, retry_cnt=0, lol_cnt=0. All internal counters are 0.
- Registered outputs; all outputs change on the clk edge after the causing event. A qualified sample is sample_en=1.
- IDLE: int_freeze=1. When en=1, go to FACQ next cycle and pulse int_clr for exactly 1 cycle, coincident with state=FACQ.
- FACQ: gains KP_F/KI_F, int_freeze=0. The dwell counter increments per qualified sample. On the ACQ_DWELL-th sample, go to PACQ, clear the window sum, window index and good-window run.
- Window: signed accumulator of width WIN_LOG2+2. It adds +1/-1 per qualified sample in PACQ/TRACK. On the 2^WIN_LOG2-th sample, the window closes and is evaluated on a total that includes that sample. The accumulator then restarts at 0, not at the closing sample.
- PACQ: gains KP_P/KI_P.
  - A good window increments the run; a bad window zeroes it.
  - When the run reaches LOCK_WINS: go to TRACK with lock=1.
  - Otherwise, after MAX_WINS windows: go back to FACQ, pulse int_clr, retry_cnt+1 (saturates at 15).
  - Lock takes precedence when both occur at the same window close.
- TRACK: gains KP_T/KI_T, lock=1.
  - A window with |sum| > UNLOCK_THR causes loss of lock: lock=0, go to FACQ, pulse int_clr, dwell restarts, lol event.
  - Windows with |sum| between LOCK_THR and UNLOCK_THR are ignored (hysteresis).
- Gain outputs follow the state with the state register (same edge).
- en=0 in any state: go to IDLE next cycle. lock=0, int_freeze=1, counters cleared, retry_cnt cleared. An en drop takes precedence over any same-cycle transition. A sample_en in that cycle is discarded.
- Asynchronous rst mid-operation: immediate return to reset values. No int_clr pulse is emitted until the next IDLE->FACQ.
- |sum| is computed as the magnitude of the two's-complement value. sum=-2^WIN_LOG2 is representable by construction.

Optional Feature:
CDR_ACQ_LOL_CNT_EN
- Defined: lol_cnt increments on each TRACK loss-of-lock event and saturates at 255. It is cleared only by rst, not by en=0.
- Undefined: no counter logic; lol_cnt tied to 0.

Decomposition:
- Package cdr_acq_pkg holds:
  - the state enum constants IDLE/FACQ/PACQ/TRACK (2-bit);
  - the gain-shift width (4);
  - the PD sign-to-±1 convention.
- Sub-module cdr_lock_win: windowed ±1 accumulator with magnitude compare. It emits a one-cycle win_done with win_good/win_bad and has a synchronous clear. The FSM, dwell counter and retry logic stay in cdr_acq_ctrl.

Test Plan:
- rst, then en=1 -> state=FACQ next cycle, int_clr high exactly 1 cycle, kp_shift=2, ki_shift=6. After 4096 strobes -> state=PACQ, kp=4, ki=9.
- In PACQ, alternating pd_sign (sum=0) for 4×256 strobes -> lock=1, state=TRACK, kp=6, ki=12 on the edge after the 1024th strobe.
- In TRACK, 256 strobes of pd_sign=1 (sum=256) -> lock=0, state=FACQ, int_clr pulse, lol_cnt=1 (0 with macro undefined). Windows with sum=64 keep lock=1.
- In PACQ, constant pd_sign=0 for 64 windows -> state=FACQ, retry_cnt=1. Repeat 16× -> retry_cnt stays 15.
- Drop en in TRACK on the cycle a window closes bad -> state=IDLE, lock=0, int_freeze=1, retry_cnt=0, lol_cnt unchanged.
- Assert rst asynchronously mid-PACQ between clock edges -> all outputs at reset values immediately. After release and en=1, the dwell restarts from 0 (4096 strobes to PACQ).

Source files
------------

// File: rtl/cdr_acq_pkg.sv
// Shared types and conventions for the CDR acquisition sequencer.
package cdr_acq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FACQ  = 2'd1,
        PACQ  = 2'd2,
        TRACK = 2'd3
    } state_t;

    localparam int GAIN_W = 4;

    // A late decision (pd_sign=1) pushes the window sum up by one.
    localparam logic PD_LATE = 1'b1;

    function automatic int pd_step(input logic pd_sign);
        return (pd_sign == PD_LATE) ? 1 : -1;
    endfunction

endpackage

// File: rtl/cdr_lock_win.sv
// Windowed +/-1 accumulator for the lock detector; the verdict is valid
// combinationally alongside the strobe that closes the window.
module cdr_lock_win
    import cdr_acq_pkg::*;
#(
    parameter int WIN_LOG2   = 8,
    parameter int LOCK_THR   = 32,
    parameter int UNLOCK_THR = 96
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic sample,
    input  logic pd_sign,
    output logic win_done,
    output logic win_good,
    output logic win_bad
);

    localparam int ACC_W = WIN_LOG2 + 2;
    localparam logic [ACC_W-1:0] LOCK_LIM   = ACC_W'(LOCK_THR);
    localparam logic [ACC_W-1:0] UNLOCK_LIM = ACC_W'(UNLOCK_THR);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] step;
    logic signed [ACC_W-1:0] total;
    logic [ACC_W-1:0]        mag;
    logic [WIN_LOG2-1:0]     idx_q;

    // The closing sample is part of the evaluated total.
    always_comb begin
        step  = ACC_W'(pd_step(pd_sign));
        total = acc_q + step;
        mag   = total[ACC_W-1] ? -total : total;
    end

    assign win_done = sample && (idx_q == '1);
    assign win_good = (mag <= LOCK_LIM);
    assign win_bad  = (mag > UNLOCK_LIM);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            idx_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
            idx_q <= '0;
        end else if (sample) begin
            if (win_done) begin
                acc_q <= '0;
                idx_q <= '0;
            end else begin
                acc_q <= total;
                idx_q <= idx_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdr_acq_ctrl.sv
// Acquisition / gear-shift sequencer for the bang-bang CDR core.
// Optional loss-of-lock event counter enabled by defining CDR_ACQ_LOL_CNT_EN.
module cdr_acq_ctrl
    import cdr_acq_pkg::*;
#(
    parameter int               WIN_LOG2   = 8,
    parameter int               ACQ_DWELL  = 4096,
    parameter int               LOCK_THR   = 32,
    parameter int               UNLOCK_THR = 96,
    parameter int               LOCK_WINS  = 4,
    parameter int               MAX_WINS   = 64,
    parameter logic [GAIN_W-1:0] KP_F      = 4'd2,
    parameter logic [GAIN_W-1:0] KP_P      = 4'd4,
    parameter logic [GAIN_W-1:0] KP_T      = 4'd6,
    parameter logic [GAIN_W-1:0] KI_F      = 4'd6,
    parameter logic [GAIN_W-1:0] KI_P      = 4'd9,
    parameter logic [GAIN_W-1:0] KI_T      = 4'd12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sample_en,
    input  logic              pd_sign,
    output logic [GAIN_W-1:0] kp_shift,
    output logic [GAIN_W-1:0] ki_shift,
    output logic              int_freeze,
    output logic              int_clr,
    output logic              lock,
    output logic [1:0]        state,
    output logic [3:0]        retry_cnt,
    output logic [7:0]        lol_cnt
);

    localparam int DWELL_W = 16;
    localparam int RUN_W   = $clog2(LOCK_WINS + 1);
    localparam int WINS_W  = $clog2(MAX_WINS + 1);

    state_t              state_q, state_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic [WINS_W-1:0]   wins_q, wins_d;
    logic [3:0]          retry_d;
    logic                clr_d;
    logic                in_win, win_sample, win_clr;
    logic                win_done, win_good, win_bad;

    // The window only runs in PACQ/TRACK and is held empty everywhere else.
    assign in_win     = (state_q == PACQ) || (state_q == TRACK);
    assign win_sample = en && sample_en && in_win;
    assign win_clr    = !en || !in_win;

    cdr_lock_win #(
        .WIN_LOG2   (WIN_LOG2),
        .LOCK_THR   (LOCK_THR),
        .UNLOCK_THR (UNLOCK_THR)
    ) u_win (
        .clk      (clk),
        .rst      (rst),
        .clr      (win_clr),
        .sample   (win_sample),
        .pd_sign  (pd_sign),
        .win_done (win_done),
        .win_good (win_good),
        .win_bad  (win_bad)
    );

    // NOTE: every signal gets a default first so this block never infers a latch.
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        run_d   = run_q;
        wins_d  = wins_q;
        retry_d = retry_cnt;
        clr_d   = 1'b0;
        if (!en) begin
            state_d = IDLE;
            dwell_d = '0;
            run_d   = '0;
            wins_d  = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = FACQ;
                    clr_d   = 1'b1;
                    dwell_d = '0;
                end
                FACQ: begin
                    if (sample_en) begin
                        if (dwell_q == DWELL_W'(ACQ_DWELL - 1)) begin
                            state_d = PACQ;
                            dwell_d = '0;
                            run_d   = '0;
                            wins_d  = '0;
                        end else begin
                            dwell_d = dwell_q + 1'b1;
                        end
                    end
                end
                PACQ: begin
                    // Reaching lock wins over a simultaneous window-budget timeout.
                    if (win_done) begin
                        if (win_good && run_q == RUN_W'(LOCK_WINS - 1)) begin
                            state_d = TRACK;
                            run_d   = '0;
                            wins_d  = '0;
                        end else if (wins_q == WINS_W'(MAX_WINS - 1)) begin
                            state_d = FACQ;
                            clr_d   = 1'b1;
                            run_d   = '0;
                            wins_d  = '0;
                            if (retry_cnt != 4'hF) retry_d = retry_cnt + 4'd1;
                        end else begin
                            wins_d = wins_q + 1'b1;
                            run_d  = win_good ? run_q + 1'b1 : '0;
                        end
                    end
                end
                TRACK: begin
                    if (win_done && win_bad) begin
                        state_d = FACQ;
                        clr_d   = 1'b1;
                        dwell_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dwell_q    <= '0;
            run_q      <= '0;
            wins_q     <= '0;
            retry_cnt  <= '0;
            int_clr    <= 1'b0;
            int_freeze <= 1'b1;
            lock       <= 1'b0;
            kp_shift   <= KP_F;
            ki_shift   <= KI_F;
        end else begin
            state_q    <= state_d;
            dwell_q    <= dwell_d;
            run_q      <= run_d;
            wins_q     <= wins_d;
            retry_cnt  <= retry_d;
            int_clr    <= clr_d;
            int_freeze <= (state_d == IDLE);
            lock       <= (state_d == TRACK);
            case (state_d)
                PACQ:    begin kp_shift <= KP_P; ki_shift <= KI_P; end
                TRACK:   begin kp_shift <= KP_T; ki_shift <= KI_T; end
                default: begin kp_shift <= KP_F; ki_shift <= KI_F; end
            endcase
        end
    end

    assign state = state_q;

`ifdef CDR_ACQ_LOL_CNT_EN
    logic       lol_evt;
    logic [7:0] lol_q;

    // Survives en=0 on purpose; only rst clears the event history.
    assign lol_evt = en && (state_q == TRACK) && win_done && win_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lol_q <= '0;
        end else if (lol_evt && lol_q != 8'hFF) begin
            lol_q <= lol_q + 8'd1;
        end
    end

    assign lol_cnt = lol_q;
`else
    assign lol_cnt = '0;
`endif

endmodule

// File: tb/tb_cdr_acq_ctrl.sv
// Directed bench for cdr_acq_ctrl: window-vector table plus hand-written
// sequences for retry saturation, en drop and asynchronous reset.
module tb_cdr_acq_ctrl;
    import cdr_acq_pkg::*;

    // Shortened dwell and window budget keep the run length modest.
    localparam int WIN       = 256;
    localparam int ACQ_DWELL = 256;
    localparam int MAX_WINS  = 6;
    localparam int N_VEC     = 26;

`ifdef CDR_ACQ_LOL_CNT_EN
    localparam bit LOL_ON = 1'b1;
`else
    localparam bit LOL_ON = 1'b0;
`endif

    typedef struct {
        int     n_late;     // late decisions in the window; -1 = FACQ dwell
        state_t exp_state;
        logic   exp_clr;
        int     exp_retry;
        int     exp_lol;    // value with the counter feature enabled
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, en, sample_en, pd_sign;
    logic [3:0] kp_shift, ki_shift;
    logic       int_freeze, int_clr, lock;
    logic [1:0] state;
    logic [3:0] retry_cnt;
    logic [7:0] lol_cnt;

    int   n_err    = 0;
    int   n_checks = 0;
    vec_t vecs [N_VEC];
    vec_t v;
    state_t prev;

    cdr_acq_ctrl #(
        .WIN_LOG2   (8),
        .ACQ_DWELL  (ACQ_DWELL),
        .LOCK_THR   (32),
        .UNLOCK_THR (96),
        .LOCK_WINS  (4),
        .MAX_WINS   (MAX_WINS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sample_en  (sample_en),
        .pd_sign    (pd_sign),
        .kp_shift   (kp_shift),
        .ki_shift   (ki_shift),
        .int_freeze (int_freeze),
        .int_clr    (int_clr),
        .lock       (lock),
        .state      (state),
        .retry_cnt  (retry_cnt),
        .lol_cnt    (lol_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_kp(input state_t s);
        case (s)
            PACQ:    return 4;
            TRACK:   return 6;
            default: return 2;
        endcase
    endfunction

    function automatic int exp_ki(input state_t s);
        case (s)
            PACQ:    return 9;
            TRACK:   return 12;
            default: return 6;
        endcase
    endfunction

    function automatic int lol_exp(input int n);
        return LOL_ON ? n : 0;
    endfunction

    task automatic check_state(input string name, input state_t s);
        check({name, ".state"},  32'(state),      32'(s));
        check({name, ".kp"},     32'(kp_shift),   32'(exp_kp(s)));
        check({name, ".ki"},     32'(ki_shift),   32'(exp_ki(s)));
        check({name, ".freeze"}, 32'(int_freeze), (s == IDLE)  ? 32'd1 : 32'd0);
        check({name, ".lock"},   32'(lock),       (s == TRACK) ? 32'd1 : 32'd0);
    endtask

    task automatic check_reset(input string name);
        check_state(name, IDLE);
        check({name, ".clr"},   32'(int_clr),   32'd0);
        check({name, ".retry"}, 32'(retry_cnt), 32'd0);
        check({name, ".lol"},   32'(lol_cnt),   32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic pd);
        sample_en = 1'b1;
        pd_sign   = pd;
        tick();
        sample_en = 1'b0;
    endtask

    // First n_late strobes are late, the rest early; unqualified gap cycles
    // with a flipped decision are sprinkled in and must be ignored.
    task automatic feed(input int n_late, input int count);
        for (int i = 0; i < count; i++) begin
            strobe(i < n_late);
            if (i % 7 == 6) begin
                pd_sign = ~pd_sign;
                tick();
            end
        end
    endtask

    task automatic dwell_to_pacq(input string name);
        feed(100, ACQ_DWELL - 1);
        check({name, ".pre"}, 32'(state), 32'(FACQ));
        strobe(1'b1);
        check({name, ".post"}, 32'(state), 32'(PACQ));
    endtask

    initial begin
        vecs[0]  = '{-1,  PACQ,  1'b0, 0, 0};
        vecs[1]  = '{144, PACQ,  1'b0, 0, 0};   // sum +32: good at the limit
        vecs[2]  = '{112, PACQ,  1'b0, 0, 0};   // sum -32: good
        vecs[3]  = '{145, PACQ,  1'b0, 0, 0};   // sum +34: bad, run cleared
        vecs[4]  = '{128, PACQ,  1'b0, 0, 0};
        vecs[5]  = '{128, PACQ,  1'b0, 0, 0};
        vecs[6]  = '{128, FACQ,  1'b1, 1, 0};   // budget spent with run=3
        vecs[7]  = '{-1,  PACQ,  1'b0, 1, 0};
        vecs[8]  = '{128, PACQ,  1'b0, 1, 0};
        vecs[9]  = '{128, PACQ,  1'b0, 1, 0};
        vecs[10] = '{128, PACQ,  1'b0, 1, 0};
        vecs[11] = '{128, TRACK, 1'b0, 1, 0};   // 4th good window -> lock
        vecs[12] = '{128, TRACK, 1'b0, 1, 0};
        vecs[13] = '{160, TRACK, 1'b0, 1, 0};   // sum +64: hysteresis band
        vecs[14] = '{176, TRACK, 1'b0, 1, 0};   // sum +96: not above limit
        vecs[15] = '{80,  TRACK, 1'b0, 1, 0};   // sum -96
        vecs[16] = '{144, TRACK, 1'b0, 1, 0};
        vecs[17] = '{177, FACQ,  1'b1, 1, 1};   // sum +98: loss of lock
        vecs[18] = '{-1,  PACQ,  1'b0, 1, 1};
        vecs[19] = '{200, PACQ,  1'b0, 1, 1};
        vecs[20] = '{250, PACQ,  1'b0, 1, 1};
        vecs[21] = '{144, PACQ,  1'b0, 1, 1};
        vecs[22] = '{112, PACQ,  1'b0, 1, 1};
        vecs[23] = '{128, PACQ,  1'b0, 1, 1};
        vecs[24] = '{128, TRACK, 1'b0, 1, 1};   // lock and timeout together
        vecs[25] = '{0,   FACQ,  1'b1, 1, 2};   // sum -256: loss of lock

        rst       = 1'b1;
        en        = 1'b0;
        sample_en = 1'b0;
        pd_sign   = 1'b0;
        #23;
        check_reset("reset");
        rst = 1'b0;
        tick();
        check_state("idle_en0", IDLE);

        en = 1'b1;
        tick();
        check_state("start", FACQ);
        check("start.clr", 32'(int_clr), 32'd1);
        tick();
        check("start.clr_width", 32'(int_clr), 32'd0);

        prev = FACQ;
        for (int i = 0; i < N_VEC; i++) begin
            v = vecs[i];
            if (v.n_late < 0) feed(100, ACQ_DWELL - 1);
            else              feed(v.n_late, WIN - 1);
            check_state($sformatf("v%0d.pre", i), prev);
            check($sformatf("v%0d.pre.clr", i), 32'(int_clr), 32'd0);
            strobe(v.n_late >= WIN);
            check_state($sformatf("v%0d", i), v.exp_state);
            check($sformatf("v%0d.clr", i),   32'(int_clr),   32'(v.exp_clr));
            check($sformatf("v%0d.retry", i), 32'(retry_cnt), 32'(v.exp_retry));
            check($sformatf("v%0d.lol", i),   32'(lol_cnt),   32'(lol_exp(v.exp_lol)));
            if (v.exp_clr) begin
                tick();
                check($sformatf("v%0d.clr_width", i), 32'(int_clr), 32'd0);
            end
            prev = v.exp_state;
        end

        // Repeated PACQ timeouts: retry_cnt climbs from 1 and saturates at 15.
        for (int k = 0; k < 16; k++) begin
            dwell_to_pacq($sformatf("retry%0d.dwell", k));
            for (int w = 0; w < MAX_WINS; w++) feed(0, WIN);
            check($sformatf("retry%0d.state", k), 32'(state), 32'(FACQ));
            check($sformatf("retry%0d.cnt", k), 32'(retry_cnt), 32'((k + 2 > 15) ? 15 : k + 2));
        end

        // en drops on the very strobe that closes a bad TRACK window.
        dwell_to_pacq("endrop.dwell");
        for (int w = 0; w < 4; w++) feed(128, WIN);
        check_state("endrop.track", TRACK);
        feed(WIN, WIN - 1);
        en        = 1'b0;
        sample_en = 1'b1;
        pd_sign   = 1'b1;
        tick();
        sample_en = 1'b0;
        check_state("endrop", IDLE);
        check("endrop.retry", 32'(retry_cnt), 32'd0);
        check("endrop.lol",   32'(lol_cnt),   32'(lol_exp(2)));
        check("endrop.clr",   32'(int_clr),   32'd0);
        tick();
        check_state("endrop.hold", IDLE);
        en = 1'b1;
        tick();
        check_state("restart", FACQ);
        check("restart.clr", 32'(int_clr), 32'd1);

        // Asynchronous reset between edges while in PACQ with retry_cnt=1.
        dwell_to_pacq("arst.dwell0");
        for (int w = 0; w < MAX_WINS; w++) feed(0, WIN);
        check("arst.retry_pre", 32'(retry_cnt), 32'd1);
        dwell_to_pacq("arst.dwell1");
        feed(128, 100);
        #3;
        rst = 1'b1;
        #1;
        check_reset("arst");
        @(posedge clk);
        #1;
        check_reset("arst.held");
        #3;
        rst = 1'b0;
        tick();
        check_state("arst.start", FACQ);
        check("arst.start.clr", 32'(int_clr), 32'd1);
        dwell_to_pacq("arst.redwell");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
